// File: rtl/lsu_mem_master.sv
// Load/store initiator: byte/half/word CPU accesses onto a word-addressed single-port memory,
// with read-modify-write for sub-word stores. Optional MISALIGN_CHECK_EN enables the misaligned-access error path.
module lsu_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    output logic                  mem_request,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            dbg_state
);

    // Handshake: an access is taken on a rising edge where cpu_valid & cpu_ready are both high;
    // cpu_ready is high only in IDLE, and completion is signalled by a single-cycle cpu_done pulse.

`ifdef MISALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_MERGE, S_WR, S_ERR} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_MERGE, S_WR} state_e;
`endif

    state_e                  state_q, state_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   merge_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merge_val;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr[31:ADDR_WIDTH+2];

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extract_lane = {{24{~uns & b[7]}}, b};
            2'b01:   extract_lane = {{16{~uns & h[15]}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        merge_lane = r;
    endfunction

    assign load_val  = extract_lane(mem_rdata, size_q, addr_q[1:0], uns_q);
    assign merge_val = merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
    assign accept    = cpu_valid & cpu_ready;

    // Memory-side outputs depend only on the latched op and state, never on live cpu_* inputs.
    assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
    assign mem_wdata = size_q[1] ? wdata_q : merge_q;
    assign dbg_state = state_q;

    // Load data is presented combinationally during RESP and held from the register afterwards.
    assign cpu_rdata = (state_q == S_RESP) ? load_val : rdata_q;

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        cpu_done    = 1'b0;
        cpu_err     = 1'b0;
        mem_request = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
`ifdef MISALIGN_CHECK_EN
                    if (((cpu_size == 2'b01) && cpu_addr[0]) ||
                        (cpu_size[1] && (cpu_addr[1:0] != 2'b00)))
                        state_d = S_ERR;
                    else
`endif
                    if (!cpu_we)
                        state_d = S_RD;
                    else if (cpu_size[1])
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                mem_request = 1'b1;
                state_d     = we_q ? S_MERGE : S_RESP;
            end
            S_RESP: begin
                cpu_done = 1'b1;
                state_d  = S_IDLE;
            end
            S_MERGE: begin
                state_d = S_WR;
            end
            S_WR: begin
                mem_request = 1'b1;
                mem_we      = 1'b1;
                cpu_done    = 1'b1;
                state_d     = S_IDLE;
            end
`ifdef MISALIGN_CHECK_EN
            S_ERR: begin
                cpu_done = 1'b1;
                cpu_err  = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= cpu_we;
                size_q  <= cpu_size;
                uns_q   <= cpu_unsigned;
                addr_q  <= cpu_addr[ADDR_WIDTH+1:0];
                wdata_q <= cpu_wdata;
            end
            if (state_q == S_RESP)  rdata_q <= load_val;
            if (state_q == S_MERGE) merge_q <= merge_val;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed cases plus random accesses, scored against a word-array
// reference model; a separate monitor checks every cpu_done against an expected queue.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_request;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] tb_mem  [128];
    logic [31:0] ref_mem [128];
    logic [31:0] rd_q;
    logic        rd_v = 1'b0;

    always @(posedge clk) begin
        if (mem_request && mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (mem_request && !mem_we) rd_q <= tb_mem[mem_addr];
        rd_v <= mem_request && !mem_we;
    end
    assign mem_rdata = rd_v ? rd_q : 32'h1234_5678;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  kind;     // 0 load, 1 store, 2 error
        logic [31:0] rdata;
        logic [6:0]  maddr;
        logic [31:0] mwdata;
        logic [3:0]  lat;
        logic [31:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain byte arithmetic on the word array.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t            e;
        int              idx, off, nb;
        longint unsigned old_w, lim, v, mask;
        bit              mis;
        e     = '0;
        idx   = int'((addr / 4) % 128);
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off   = int'(addr % 4) / nb * nb;
`ifdef MISALIGN_CHECK_EN
        mis   = (addr % nb) != 0;
`else
        mis   = 1'b0;
`endif
        lim   = longint'(1) << (8 * nb);
        old_w = longint'(ref_mem[idx]);
        e.maddr = 7'(idx);
        if (mis) begin
            e.kind = 2'd2;
            e.lat  = 4'd1;
        end else if (!we) begin
            v = (old_w >> (8 * off)) % lim;
            if (!uns && (v >= lim / 2)) v = v + 64'h1_0000_0000 - lim;
            e.kind  = 2'd0;
            e.rdata = v[31:0];
            e.lat   = 4'd2;
        end else begin
            mask = (lim - 1) << (8 * off);
            v = (old_w & ~mask) | ((longint'(wdata) % lim) << (8 * off));
            ref_mem[idx] = v[31:0];
            e.kind   = 2'd1;
            e.mwdata = v[31:0];
            e.lat    = (nb == 4) ? 4'd1 : 4'd3;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cpu_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("latency", 32'(cyc - int'(e.acc) + 1), 32'(e.lat));
                chk("err", 32'(cpu_err), (e.kind == 2'd2) ? 32'd1 : 32'd0);
                case (e.kind)
                    2'd0: begin
                        chk("rdata", cpu_rdata, e.rdata);
                        chk("load_req", 32'(mem_request), 32'd0);
                    end
                    2'd1: begin
                        chk("store_req_we", {30'd0, mem_request, mem_we}, 32'd3);
                        chk("store_addr", 32'(mem_addr), 32'(e.maddr));
                        chk("store_wdata", mem_wdata, e.mwdata);
                    end
                    default: chk("err_req", 32'(mem_request), 32'd0);
                endcase
            end
        end
    end

    // Flags any write issued while a reset-aborted RMW is being watched.
    logic watch  = 1'b0;
    logic bad_wr = 1'b0;
    always @(posedge clk) if (watch && mem_request && mem_we) bad_wr <= 1'b1;

    // ---------------- driver ----------------
    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        int   n;
        exp_t e;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) begin
            checks++;
            $display("FAIL accept_timeout actual=%0b required=1", cpu_ready);
            cpu_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        if (track) begin
            e = model(we, size, uns, addr, wdata);
            e.acc = 32'(cyc);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_req", 32'(mem_request), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);

        // word store / load
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hA5A5_1234, 1'b1);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        // byte RMW into a cleared word
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        do_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h1FF, 1'b1);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        // sign / zero extension
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_00FF, 1'b1);
        do_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1);
        do_op(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b1);
        do_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1);
        do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
        // misaligned word load
        do_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1);
        // size 11 behaves as word
        do_op(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b1);
        drain();

        // reset during MERGE of a half store must leave memory untouched
        watch = 1'b1;
        do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrst_req", 32'(mem_request), 32'd0);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        watch = 1'b0;
        chk("midrst_no_write", 32'(bad_wr), 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        for (int i = 0; i < 128; i++) chk("mem_image", tb_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
